timer_counter: RTL and testbench

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_pkg.sv | 32 +++
 rtl/timer_prescaler.sv | 37 +++
 rtl/timer_counter.sv | 70 +++++++
 tb/tb_timer_counter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer/counter block.
// Holds the tick-rate select encodings, the prescaler and counter widths,
// and a helper that maps a rate select onto the prescaler compare mask.
package timer_pkg;

  localparam int unsigned SEL_W = 2;
  localparam int unsigned PSC_W = 4;
  localparam int unsigned CNT_W = 8;

  // Tick-rate select: tick period is 2^(sel+1) clocks.
  typedef enum logic [SEL_W-1:0] {
    CLK_SEL_DIV2  = 2'b00,
    CLK_SEL_DIV4  = 2'b01,
    CLK_SEL_DIV8  = 2'b10,
    CLK_SEL_DIV16 = 2'b11
  } clk_sel_e;

  // Low (sel+1) bits set; a tick fires when those prescaler bits are all ones.
  function automatic logic [PSC_W-1:0] sel_mask(input clk_sel_e sel);
    logic [PSC_W-1:0] mask;
    mask = PSC_W'(4'b0001);
    case (sel)
      CLK_SEL_DIV2:  mask = PSC_W'(4'b0001);
      CLK_SEL_DIV4:  mask = PSC_W'(4'b0011);
      CLK_SEL_DIV8:  mask = PSC_W'(4'b0111);
      CLK_SEL_DIV16: mask = PSC_W'(4'b1111);
      default:       mask = PSC_W'(4'b0001);
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running 4-bit prescaler with selectable tick rate.
// Ports:
//   CLK        - system clock, rising edge
//   RST        - synchronous active-high reset
//   CLK_SEL_IN - rate select (00 /2, 01 /4, 10 /8, 11 /16)
//   clear      - holds the prescaler at zero and suppresses ticks
//   tick       - combinational tick, high for one cycle per period
module timer_prescaler
  import timer_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [SEL_W-1:0] CLK_SEL_IN,
  input  logic             clear,
  output logic             tick
);

  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] mask;

  // Prescaler counts while not cleared; wraps 15 -> 0 naturally.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      psc <= '0;
    end else begin
      psc <= psc + PSC_W'(1);
    end
  end

  // Rate select is applied directly to the compare so a switch never
  // resets the prescaler; at most one compare can match per cycle.
  always_comb begin
    mask = sel_mask(clk_sel_e'(CLK_SEL_IN));
    tick = !clear && ((psc & mask) == mask);
  end

endmodule

// File: rtl/timer_counter.sv
// 8-bit up/down timer counter with loadable value and prescaled tick.
// Ports:
//   CLK        - system clock, rising edge
//   RST        - synchronous active-high reset, overrides everything
//   CLK_SEL_IN - tick-rate select (00 /2, 01 /4, 10 /8, 11 /16)
//   TDR_IN     - load value
//   LOAD_IN    - level load request; counter follows TDR_IN while high
//   UPDW_IN    - direction, 0 up / 1 down, sampled on tick edges only
//   EN_IN      - counting enable
//   CNT_OUT    - registered counter value
//   OVF_OUT    - registered one-cycle pulse on 0xFF -> 0x00 wrap
//   UNDF_OUT   - registered one-cycle pulse on 0x00 -> 0xFF wrap
module timer_counter
  import timer_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [SEL_W-1:0] CLK_SEL_IN,
  input  logic [CNT_W-1:0] TDR_IN,
  input  logic             LOAD_IN,
  input  logic             UPDW_IN,
  input  logic             EN_IN,
  output logic [CNT_W-1:0] CNT_OUT,
  output logic             OVF_OUT,
  output logic             UNDF_OUT
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic psc_clear;
  logic tick;

  // Disable or load both park the prescaler so counting restarts cleanly.
  assign psc_clear = !EN_IN || LOAD_IN;

  timer_prescaler u_prescaler (
    .CLK        (CLK),
    .RST        (RST),
    .CLK_SEL_IN (CLK_SEL_IN),
    .clear      (psc_clear),
    .tick       (tick)
  );

  // Counter and wrap flags: reset, then load, then tick, else hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      CNT_OUT  <= '0;
      OVF_OUT  <= 1'b0;
      UNDF_OUT <= 1'b0;
    end else if (LOAD_IN) begin
      CNT_OUT  <= TDR_IN;
      OVF_OUT  <= 1'b0;
      UNDF_OUT <= 1'b0;
    end else if (tick) begin
      if (!UPDW_IN) begin
        CNT_OUT  <= CNT_OUT + CNT_W'(1);
        OVF_OUT  <= (CNT_OUT == CNT_MAX);
        UNDF_OUT <= 1'b0;
      end else begin
        CNT_OUT  <= CNT_OUT - CNT_W'(1);
        OVF_OUT  <= 1'b0;
        UNDF_OUT <= (CNT_OUT == '0);
      end
    end else begin
      OVF_OUT  <= 1'b0;
      UNDF_OUT <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: table of scenario vectors plus
// hand-written multi-cycle sequences, expectations queued in a scoreboard.
module tb_timer_counter;

  logic       CLK;
  logic       RST;
  logic [1:0] CLK_SEL_IN;
  logic [7:0] TDR_IN;
  logic       LOAD_IN;
  logic       UPDW_IN;
  logic       EN_IN;
  logic [7:0] CNT_OUT;
  logic       OVF_OUT;
  logic       UNDF_OUT;

  timer_counter dut (
    .CLK        (CLK),
    .RST        (RST),
    .CLK_SEL_IN (CLK_SEL_IN),
    .TDR_IN     (TDR_IN),
    .LOAD_IN    (LOAD_IN),
    .UPDW_IN    (UPDW_IN),
    .EN_IN      (EN_IN),
    .CNT_OUT    (CNT_OUT),
    .OVF_OUT    (OVF_OUT),
    .UNDF_OUT   (UNDF_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [7:0] cnt;
    logic       ovf;
    logic       undf;
  } exp_t;

  typedef struct {
    string      name;
    bit         do_load;
    logic [7:0] tdr;
    logic [1:0] sel;
    bit         updw;
    bit         en;
    int         n;
    logic [7:0] cnt;
    bit         ovf;
    bit         undf;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[16];
  int   checks = 0;
  int   errors = 0;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input string nm, input logic [7:0] c, input logic o, input logic u);
    exp_t e;
    e.name = nm;
    e.cnt  = c;
    e.ovf  = o;
    e.undf = u;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expectation queued");
    end else begin
      e = sb.pop_front();
      if (CNT_OUT !== e.cnt || OVF_OUT !== e.ovf || UNDF_OUT !== e.undf) begin
        errors++;
        $display("FAIL %s: got cnt=%02h ovf=%b undf=%b, want cnt=%02h ovf=%b undf=%b",
                 e.name, CNT_OUT, OVF_OUT, UNDF_OUT, e.cnt, e.ovf, e.undf);
      end
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; LOAD_IN = 1'b0; EN_IN = 1'b0; UPDW_IN = 1'b0;
    CLK_SEL_IN = 2'b00; TDR_IN = 8'h00;
    step();
    step();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; LOAD_IN = 1'b0; EN_IN = 1'b0; UPDW_IN = 1'b0;
    CLK_SEL_IN = 2'b00; TDR_IN = 8'h00;

    // name, load, tdr, sel, updw, en, edges, cnt, ovf, undf
    vecs[0]  = '{"reset_state",   1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 0,  8'h00, 1'b0, 1'b0};
    vecs[1]  = '{"div2_up_1clk",  1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1,  8'h00, 1'b0, 1'b0};
    vecs[2]  = '{"div2_up_2clk",  1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 2,  8'h01, 1'b0, 1'b0};
    vecs[3]  = '{"div2_up_4clk",  1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 4,  8'h02, 1'b0, 1'b0};
    vecs[4]  = '{"ovf_pre",       1'b1, 8'hFE, 2'b01, 1'b0, 1'b1, 4,  8'hFF, 1'b0, 1'b0};
    vecs[5]  = '{"ovf_wrap",      1'b1, 8'hFE, 2'b01, 1'b0, 1'b1, 8,  8'h00, 1'b1, 1'b0};
    vecs[6]  = '{"ovf_one_cycle", 1'b1, 8'hFE, 2'b01, 1'b0, 1'b1, 9,  8'h00, 1'b0, 1'b0};
    vecs[7]  = '{"undf_pre",      1'b1, 8'h01, 2'b11, 1'b1, 1'b1, 16, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{"undf_wrap",     1'b1, 8'h01, 2'b11, 1'b1, 1'b1, 32, 8'hFF, 1'b0, 1'b1};
    vecs[9]  = '{"undf_one_cyc",  1'b1, 8'h01, 2'b11, 1'b1, 1'b1, 33, 8'hFF, 1'b0, 1'b0};
    vecs[10] = '{"div8_before",   1'b0, 8'h00, 2'b10, 1'b0, 1'b1, 7,  8'h00, 1'b0, 1'b0};
    vecs[11] = '{"div8_first",    1'b0, 8'h00, 2'b10, 1'b0, 1'b1, 8,  8'h01, 1'b0, 1'b0};
    vecs[12] = '{"div8_third",    1'b0, 8'h00, 2'b10, 1'b0, 1'b1, 24, 8'h03, 1'b0, 1'b0};
    vecs[13] = '{"div2_down",     1'b1, 8'h80, 2'b00, 1'b1, 1'b1, 10, 8'h7B, 1'b0, 1'b0};
    vecs[14] = '{"disabled_hold", 1'b1, 8'h42, 2'b00, 1'b0, 1'b0, 20, 8'h42, 1'b0, 1'b0};
    vecs[15] = '{"div16_up",      1'b1, 8'h10, 2'b11, 1'b0, 1'b1, 48, 8'h13, 1'b0, 1'b0};

    foreach (vecs[i]) begin
      do_reset();
      if (vecs[i].do_load) begin
        LOAD_IN = 1'b1; TDR_IN = vecs[i].tdr; EN_IN = vecs[i].en;
        step();
        LOAD_IN = 1'b0;
      end
      CLK_SEL_IN = vecs[i].sel; UPDW_IN = vecs[i].updw; EN_IN = vecs[i].en;
      push_exp(vecs[i].name, vecs[i].cnt, vecs[i].ovf, vecs[i].undf);
      for (int k = 0; k < vecs[i].n; k++) step();
      pop_check();
    end

    // Load held with counting enabled: value pinned, no overflow.
    do_reset();
    LOAD_IN = 1'b1; TDR_IN = 8'hFF; EN_IN = 1'b1; UPDW_IN = 1'b0; CLK_SEL_IN = 2'b00;
    for (int k = 0; k < 40; k++) begin
      push_exp("load_priority", 8'hFF, 1'b0, 1'b0);
      step();
      pop_check();
    end
    LOAD_IN = 1'b0;

    // Enable drop freezes value; reset discards a pending tick.
    do_reset();
    EN_IN = 1'b1; CLK_SEL_IN = 2'b00; UPDW_IN = 1'b0;
    for (int k = 0; k < 10; k++) step();
    push_exp("en_mid_count", 8'h05, 1'b0, 1'b0);
    pop_check();
    EN_IN = 1'b0;
    for (int k = 0; k < 7; k++) begin
      push_exp("en_low_hold", 8'h05, 1'b0, 1'b0);
      step();
      pop_check();
    end
    EN_IN = 1'b1;
    push_exp("en_restart", 8'h05, 1'b0, 1'b0);
    step();
    pop_check();
    // Prescaler now at 1: a tick would fire on the next edge without reset.
    RST = 1'b1;
    push_exp("rst_pending_tick", 8'h00, 1'b0, 1'b0);
    step();
    pop_check();
    RST = 1'b0;
    push_exp("rst_release_1", 8'h00, 1'b0, 1'b0);
    step();
    pop_check();
    push_exp("rst_release_2", 8'h01, 1'b0, 1'b0);
    step();
    pop_check();

    // Rate switch /2 -> /16 mid-count at prescaler value 6.
    do_reset();
    EN_IN = 1'b1; CLK_SEL_IN = 2'b00; UPDW_IN = 1'b0;
    for (int k = 0; k < 6; k++) step();
    push_exp("switch_before", 8'h03, 1'b0, 1'b0);
    pop_check();
    CLK_SEL_IN = 2'b11;
    for (int e = 7; e <= 40; e++) begin
      logic [7:0] want;
      want = (e < 16) ? 8'h03 : ((e < 32) ? 8'h04 : 8'h05);
      push_exp("rate_switch", want, 1'b0, 1'b0);
      step();
      pop_check();
    end

    // Direction flip between ticks does not disturb the held value.
    do_reset();
    EN_IN = 1'b1; CLK_SEL_IN = 2'b11; UPDW_IN = 1'b0;
    for (int k = 0; k < 16; k++) step();
    push_exp("dir_first_tick", 8'h01, 1'b0, 1'b0);
    pop_check();
    for (int k = 0; k < 15; k++) begin
      UPDW_IN = k[0];
      push_exp("dir_between", 8'h01, 1'b0, 1'b0);
      step();
      pop_check();
    end
    UPDW_IN = 1'b1;
    push_exp("dir_sampled", 8'h00, 1'b0, 1'b0);
    step();
    pop_check();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
